// File: rtl/matmul_host.sv
// Host-side initiator for the 3x3 byte matrix multiplier: loads 18 operand
// bytes, runs the trigger/ready handshake, then streams the 9 result bytes.
module matmul_host #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_rx_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_mm_trigger,
    output logic [7:0] o_mm_a [9],
    output logic [7:0] o_mm_b [9],
    input  logic       i_mm_ready,
    input  logic [7:0] i_mm_result [9],
    output logic       o_busy
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        LOAD,
        TRIG,
        WAIT_HIGH,
        SETTLE,
        SEND
    } state_t;

    state_t        r_state;
    logic [4:0]    r_cnt;
    logic [3:0]    r_idx;
    logic [SW-1:0] r_settle;
    logic          r_seen_high;
    logic [7:0]    r_res [9];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= LOAD;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_settle     <= '0;
            r_seen_high  <= 1'b0;
            o_rx_ready   <= 1'b1;
            o_tx_valid   <= 1'b0;
            o_tx_data    <= '0;
            o_mm_trigger <= 1'b0;
            o_busy       <= 1'b0;
            for (int unsigned i = 0; i < 9; i++) begin
                o_mm_a[i] <= '0;
                o_mm_b[i] <= '0;
                r_res[i]  <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (i_rx_valid && o_rx_ready) begin
                        if (r_cnt < 5'd9) begin
                            o_mm_a[r_cnt[3:0]] <= i_rx_data;
                        end else begin
                            o_mm_b[4'(r_cnt - 5'd9)] <= i_rx_data;
                        end
                        o_busy <= 1'b1;
                        if (r_cnt == 5'd17) begin
                            r_state      <= TRIG;
                            o_rx_ready   <= 1'b0;
                            o_mm_trigger <= 1'b1;
                            r_seen_high  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                // Trigger is only released after ready has been seen high and then low,
                // so a multiplier that was still busy on entry cannot miss the request.
                TRIG: begin
                    if (i_mm_ready) begin
                        r_seen_high <= 1'b1;
                    end else if (r_seen_high) begin
                        o_mm_trigger <= 1'b0;
                        r_state      <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (i_mm_ready) begin
                        r_settle <= SW'(SETTLE_CYCLES);
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (r_settle == '0) begin
                        r_res      <= i_mm_result;
                        r_idx      <= '0;
                        o_tx_data  <= i_mm_result[0];
                        o_tx_valid <= 1'b1;
                        r_state    <= SEND;
                    end else begin
                        r_settle <= r_settle - SW'(1);
                    end
                end
                SEND: begin
                    if (i_tx_ready) begin
                        if (r_idx == 4'd8) begin
                            o_tx_valid <= 1'b0;
                            o_rx_ready <= 1'b1;
                            o_busy     <= 1'b0;
                            r_cnt      <= '0;
                            r_state    <= LOAD;
                        end else begin
                            r_idx     <= r_idx + 4'd1;
                            o_tx_data <= r_res[r_idx + 4'd1];
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_host.sv
// Randomized self-checking bench for matmul_host with a behavioural
// multiplier model and a matrix-product scoreboard on the tx stream.
module tb_matmul_host;

    localparam int unsigned SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       mm_trigger;
    logic       mm_ready;
    logic       busy;
    logic [7:0] mm_a [9];
    logic [7:0] mm_b [9];
    logic [7:0] mm_result [9];

    always #5 clk = ~clk;

    matmul_host #(.SETTLE_CYCLES(SETTLE)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_mm_trigger (mm_trigger),
        .o_mm_a       (mm_a),
        .o_mm_b       (mm_b),
        .i_mm_ready   (mm_ready),
        .i_mm_result  (mm_result),
        .o_busy       (busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Multiplier model: accepts a trigger while ready, drops ready one cycle
    // later, raises it one cycle after that with the product on the result bus.
    int         mm_phase;
    int         mm_accepts = 0;
    logic       mm_block = 1'b0;
    logic [7:0] pend [9];

    always @(posedge clk or negedge rst_n) begin : mm_model
        int s;
        if (!rst_n) begin
            mm_ready <= 1'b1;
            mm_phase <= 0;
            for (int i = 0; i < 9; i++) mm_result[i] <= 8'h00;
        end else begin
            case (mm_phase)
                0: begin
                    if (mm_block) begin
                        mm_ready <= 1'b0;
                    end else begin
                        mm_ready <= 1'b1;
                        if (mm_trigger && mm_ready) begin
                            for (int r = 0; r < 3; r++)
                                for (int c = 0; c < 3; c++) begin
                                    s = 0;
                                    for (int k = 0; k < 3; k++)
                                        s += int'(mm_a[r*3+k]) * int'(mm_b[k*3+c]);
                                    pend[r*3+c] <= 8'(s);
                                end
                            mm_accepts <= mm_accepts + 1;
                            mm_phase   <= 1;
                        end
                    end
                end
                1: begin
                    mm_ready <= 1'b0;
                    for (int i = 0; i < 9; i++) mm_result[i] <= 8'($urandom);
                    mm_phase <= 2;
                end
                default: begin
                    mm_ready  <= 1'b1;
                    mm_result <= pend;
                    mm_phase  <= 0;
                end
            endcase
        end
    end

    // Scoreboard: expected result bytes in tx order.
    logic [7:0] exp_q [$];
    logic [7:0] cur_job [$];

    task automatic push_expected();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                int s = 0;
                for (int k = 0; k < 3; k++)
                    s += int'(cur_job[r*3+k]) * int'(cur_job[9 + k*3+c]);
                exp_q.push_back(8'(s % 256));
            end
    endtask

    int         rx_accepts = 0;
    int         trig_cycles = 0;
    logic       stalled = 1'b0;
    logic [7:0] held;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (rx_valid && rx_ready) rx_accepts++;
            if (mm_trigger) trig_cycles++;
            if (tx_valid) begin
                if (stalled) check_eq("tx_hold", int'(tx_data), int'(held));
                if (tx_ready) begin
                    if (exp_q.size() == 0) check_eq("tx_extra", 1, 0);
                    else check_eq("tx_data", int'(tx_data), int'(exp_q.pop_front()));
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = tx_data;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    int tx_mode = 0;
    int tx_ph = 0;
    always @(posedge clk) begin
        #1;
        if (tx_mode == 0) begin
            tx_ready = 1'b1;
        end else begin
            tx_ready = (tx_ph == 0 || tx_ph == 3);
            tx_ph    = (tx_ph + 1) % 4;
        end
    end

    task automatic send_byte(input logic [7:0] d);
        int t = 0;
        rx_data  = d;
        rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_ready) break;
            t++;
            if (t > 5000) begin
                check_eq("rx_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        cur_job.push_back(d);
        if (cur_job.size() == 18) begin
            push_expected();
            cur_job.delete();
        end
    endtask

    task automatic send_stream(input logic [7:0] q [$], input int gap_max, input bit hold_valid);
        foreach (q[i]) begin
            if (!hold_valid && gap_max > 0) begin
                int n = $urandom_range(gap_max, 0);
                rx_valid = 1'b0;
                repeat (n) begin @(posedge clk); #1; end
            end
            send_byte(q[i]);
        end
        rx_valid = 1'b0;
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] q [$]);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("idle_timeout", int'(t < 5000), 1);
        check_eq("busy_after", int'(busy), 0);
    endtask

    task automatic wait_trigger();
        int t = 0;
        while (!mm_trigger && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_eq("trig_timeout", int'(t < 2000), 1);
    endtask

    task automatic check_reset(input string tag);
        logic [7:0] nz = 8'h00;
        for (int i = 0; i < 9; i++) nz |= mm_a[i] | mm_b[i];
        check_eq({tag, "_rx_ready"}, int'(rx_ready), 1);
        check_eq({tag, "_tx_valid"}, int'(tx_valid), 0);
        check_eq({tag, "_tx_data"}, int'(tx_data), 0);
        check_eq({tag, "_trigger"}, int'(mm_trigger), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_operands"}, int'(nz), 0);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check_reset(tag);
        exp_q.delete();
        cur_job.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] q [$];
        int base;
        int t;

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        q = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1,
              8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        base = mm_accepts;
        trig_cycles = 0;
        send_stream(q, 0, 1'b0);
        wait_idle();
        check_eq("ident_episodes", mm_accepts - base, 1);
        check_eq("ident_trig_cycles", trig_cycles, 3);

        q.delete();
        repeat (18) q.push_back(8'd16);
        send_stream(q, 0, 1'b0);
        wait_idle();
        q.delete();
        repeat (9) q.push_back(8'd1);
        repeat (9) q.push_back(8'd2);
        send_stream(q, 2, 1'b0);
        wait_idle();

        tx_mode = 1;
        base = rx_accepts;
        rand_bytes(54, q);
        send_stream(q, 3, 1'b0);
        wait_idle();
        check_eq("bp_rx_count", rx_accepts - base, 54);
        tx_mode = 0;

        base = rx_accepts;
        rand_bytes(36, q);
        fork
            send_stream(q, 0, 1'b1);
            begin
                wait_trigger();
                repeat (2) @(negedge clk);
                check_eq("overrun_rx_ready", int'(rx_ready), 0);
                check_eq("overrun_count", rx_accepts - base, 18);
            end
        join
        wait_idle();
        check_eq("overrun_total", rx_accepts - base, 36);

        mm_block = 1'b1;
        base = mm_accepts;
        rand_bytes(18, q);
        fork
            send_stream(q, 1, 1'b0);
            begin
                wait_trigger();
                repeat (5) @(negedge clk);
                check_eq("lowentry_trig_held", int'(mm_trigger), 1);
                check_eq("lowentry_no_accept", mm_accepts - base, 0);
                mm_block = 1'b0;
            end
        join
        wait_idle();
        check_eq("lowentry_episodes", mm_accepts - base, 1);

        base = mm_accepts;
        rand_bytes(18, q);
        send_stream(q, 0, 1'b0);
        t = 0;
        while (mm_accepts == base && t < 500) begin @(negedge clk); t++; end
        while (mm_ready && t < 500) begin @(negedge clk); t++; end
        while (!mm_ready && t < 500) begin @(negedge clk); t++; end
        check_eq("settle_reach", int'(t < 500), 1);
        @(posedge clk); #1;
        check_eq("settle_no_tx", int'(tx_valid), 0);
        pulse_reset("rst_settle");

        rand_bytes(10, q);
        send_stream(q, 1, 1'b0);
        pulse_reset("rst_load10");

        rand_bytes(18, q);
        send_stream(q, 2, 1'b0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
